store_queue_fwd: RTL and testbench

// Parametrised circular store queue between dispatch/ROB and the D-cache. Allocates N_DIS stores per cycle, takes

---
 rtl/store_queue_fwd.sv | 209 ++++++++++++++++++++
 tb/tb_store_queue_fwd.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue_fwd.sv
// Circular store queue: dispatch allocation, execute writes, ROB commit, in-order
// drain to the D-cache, and youngest-first store-to-load forwarding with byte overlap.
module store_queue_fwd #(
  parameter int DEPTH = 8,
  parameter int N_DIS = 2,
  parameter int N_EX  = 2,
  parameter int N_LD  = 2,
  parameter int XLEN  = 32,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int PTR_W  = IDX_W + 1,
  localparam int CNT_W  = $clog2(N_DIS + 1),
  localparam int FREE_W = $clog2(DEPTH + 1),
  localparam int AW     = XLEN + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [CNT_W-1:0]        dis_cnt,
  output logic [N_DIS*IDX_W-1:0]  dis_idx,
  output logic [PTR_W-1:0]        sq_tail,
  output logic [FREE_W-1:0]       free_cnt,
  output logic                    empty,
  output logic                    full,
  input  logic [N_EX-1:0]         ex_valid,
  input  logic [N_EX*IDX_W-1:0]   ex_idx,
  input  logic [N_EX*XLEN-1:0]    ex_addr,
  input  logic [N_EX*XLEN-1:0]    ex_data,
  input  logic [N_EX*2-1:0]       ex_size,
  input  logic [CNT_W-1:0]        ret_cnt,
  input  logic                    flush,
  output logic                    dc_valid,
  output logic [XLEN-1:0]         dc_addr,
  output logic [XLEN-1:0]         dc_data,
  output logic [1:0]              dc_size,
  input  logic                    dc_ready,
  input  logic [N_LD-1:0]         ld_valid,
  input  logic [N_LD*PTR_W-1:0]   ld_sq_tail,
  input  logic [N_LD*XLEN-1:0]    ld_addr,
  input  logic [N_LD*2-1:0]       ld_size,
  output logic [N_LD-1:0]         ld_hit,
  output logic [N_LD-1:0]         ld_stall,
  output logic [N_LD*XLEN-1:0]    ld_data
);

  logic [PTR_W-1:0] head, commit_ptr, tail;
  logic [PTR_W-1:0] head_next, commit_next, tail_next, occ, squash_span;
  logic [DEPTH-1:0] alloc, addr_ok;
  logic [XLEN-1:0]  st_addr [DEPTH];
  logic [XLEN-1:0]  st_data [DEPTH];
  logic [1:0]       st_size [DEPTH];

  logic             dis_ok, drain;
  logic [DEPTH-1:0] new_alloc, clear, ex_we;
  logic [XLEN-1:0]  wr_addr [DEPTH];
  logic [XLEN-1:0]  wr_data [DEPTH];
  logic [1:0]       wr_size [DEPTH];
  logic [IDX_W-1:0] off_t, off_c;

  logic [PTR_W-1:0] f_snap, f_cnt;
  logic [IDX_W-1:0] f_idx;
  logic             f_done;
  logic [AW-1:0]    l_lo, l_hi, s_lo, s_hi;
  logic [1:0]       f_shift;

  function automatic logic [AW-1:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return AW'(1);
      2'd1:    return AW'(2);
      default: return AW'(4);
    endcase
  endfunction

  function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return XLEN'(8'hFF);
      2'd1:    return XLEN'(16'hFFFF);
      default: return XLEN'(32'hFFFF_FFFF);
    endcase
  endfunction

  assign occ      = tail - head;
  assign free_cnt = FREE_W'(DEPTH) - FREE_W'(occ);
  assign empty    = (occ == '0);
  assign full     = (occ == PTR_W'(DEPTH));
  assign sq_tail  = tail;

  for (genvar k = 0; k < N_DIS; k++) begin : g_dis
    assign dis_idx[k*IDX_W +: IDX_W] = tail[IDX_W-1:0] + IDX_W'(k);
  end

  assign dc_valid = (head != commit_ptr);
  assign dc_addr  = st_addr[head[IDX_W-1:0]];
  assign dc_data  = st_data[head[IDX_W-1:0]];
  assign dc_size  = st_size[head[IDX_W-1:0]];

  // All next pointers come from current registers; flush pulls tail back to the post-retire commit point.
  assign drain       = dc_valid && dc_ready;
  assign dis_ok      = !flush && (int'(dis_cnt) <= int'(free_cnt));
  assign commit_next = commit_ptr + PTR_W'(ret_cnt);
  assign head_next   = head + PTR_W'(drain);
  assign tail_next   = flush ? commit_next : (dis_ok ? tail + PTR_W'(dis_cnt) : tail);
  assign squash_span = tail - commit_next;

  always_comb begin
    off_t = '0;
    off_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      new_alloc[i] = 1'b0;
      clear[i]     = 1'b0;
      ex_we[i]     = 1'b0;
      wr_addr[i]   = st_addr[i];
      wr_data[i]   = st_data[i];
      wr_size[i]   = st_size[i];
      off_t        = IDX_W'(i) - tail[IDX_W-1:0];
      off_c        = IDX_W'(i) - commit_next[IDX_W-1:0];
      new_alloc[i] = dis_ok && (int'(off_t) < int'(dis_cnt));
      clear[i]     = (flush && (int'(off_c) < int'(squash_span))) ||
                     (drain && (IDX_W'(i) == head[IDX_W-1:0]));
      // Ascending port order lets the higher port win a same-entry collision.
      for (int p = 0; p < N_EX; p++) begin
        if (ex_valid[p] && (ex_idx[p*IDX_W +: IDX_W] == IDX_W'(i))) begin
          ex_we[i]   = alloc[i] && !flush;
          wr_addr[i] = ex_addr[p*XLEN +: XLEN];
          wr_data[i] = ex_data[p*XLEN +: XLEN];
          wr_size[i] = ex_size[p*2 +: 2];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= '0;
      commit_ptr <= '0;
      tail       <= '0;
      alloc      <= '0;
      addr_ok    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        st_addr[i] <= '0;
        st_data[i] <= '0;
        st_size[i] <= '0;
      end
    end else begin
      head       <= head_next;
      commit_ptr <= commit_next;
      tail       <= tail_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (clear[i]) begin
          alloc[i]   <= 1'b0;
          addr_ok[i] <= 1'b0;
        end else if (new_alloc[i]) begin
          alloc[i]   <= 1'b1;
          addr_ok[i] <= 1'b0;
        end else if (ex_we[i]) begin
          addr_ok[i] <= 1'b1;
          st_addr[i] <= wr_addr[i];
          st_data[i] <= wr_data[i];
          st_size[i] <= wr_size[i];
        end
      end
    end
  end

  // Walk older stores youngest-first; the first unknown-address or overlapping entry decides.
  always_comb begin
    ld_hit   = '0;
    ld_stall = '0;
    ld_data  = '0;
    f_snap   = '0;
    f_cnt    = '0;
    f_idx    = '0;
    f_done   = 1'b0;
    l_lo     = '0;
    l_hi     = '0;
    s_lo     = '0;
    s_hi     = '0;
    f_shift  = '0;
    for (int l = 0; l < N_LD; l++) begin
      f_snap = ld_sq_tail[l*PTR_W +: PTR_W];
      f_cnt  = f_snap - head;
      f_done = 1'b0;
      l_lo   = {1'b0, ld_addr[l*XLEN +: XLEN]};
      l_hi   = l_lo + size_bytes(ld_size[l*2 +: 2]);
      if (ld_valid[l]) begin
        for (int j = 0; j < DEPTH; j++) begin
          f_idx = f_snap[IDX_W-1:0] - IDX_W'(j + 1);
          s_lo  = {1'b0, st_addr[f_idx]};
          s_hi  = s_lo + size_bytes(st_size[f_idx]);
          if (!f_done && (j < int'(f_cnt))) begin
            if (!addr_ok[f_idx]) begin
              ld_stall[l] = 1'b1;
              f_done      = 1'b1;
            end else if ((l_lo < s_hi) && (s_lo < l_hi)) begin
              f_done = 1'b1;
              if ((s_lo <= l_lo) && (l_hi <= s_hi)) begin
                f_shift                 = ld_addr[l*XLEN +: 2] - st_addr[f_idx][1:0];
                ld_hit[l]               = 1'b1;
                ld_data[l*XLEN +: XLEN] = (st_data[f_idx] >> {f_shift, 3'b000}) &
                                          size_mask(ld_size[l*2 +: 2]);
              end else begin
                ld_stall[l] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_store_queue_fwd.sv
// Bench for store_queue_fwd: directed scenarios plus a randomized phase, all checked
// against a sequence-numbered store model with byte-level forwarding.
module tb_store_queue_fwd;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int MAXS  = 4096;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  dis_cnt, ret_cnt;
  logic [5:0]  dis_idx;
  logic [3:0]  sq_tail, free_cnt;
  logic        empty, full;
  logic [1:0]  ex_valid;
  logic [5:0]  ex_idx;
  logic [63:0] ex_addr, ex_data;
  logic [3:0]  ex_size;
  logic        flush;
  logic        dc_valid, dc_ready;
  logic [31:0] dc_addr, dc_data;
  logic [1:0]  dc_size;
  logic [1:0]  ld_valid, ld_hit, ld_stall;
  logic [7:0]  ld_sq_tail;
  logic [63:0] ld_addr, ld_data;
  logic [3:0]  ld_size;
  int          ld_snap [2];

  // Model: stores numbered by absolute sequence; head/commit/tail are plain integers.
  int          m_head, m_commit, m_tail;
  logic        m_ok   [MAXS];
  logic [31:0] m_addr [MAXS];
  logic [31:0] m_data [MAXS];
  logic [1:0]  m_size [MAXS];
  int          n_checks = 0;
  int          n_fail   = 0;

  store_queue_fwd dut (
    .clock(clock), .reset(reset), .dis_cnt(dis_cnt), .dis_idx(dis_idx), .sq_tail(sq_tail),
    .free_cnt(free_cnt), .empty(empty), .full(full), .ex_valid(ex_valid), .ex_idx(ex_idx),
    .ex_addr(ex_addr), .ex_data(ex_data), .ex_size(ex_size), .ret_cnt(ret_cnt), .flush(flush),
    .dc_valid(dc_valid), .dc_addr(dc_addr), .dc_data(dc_data), .dc_size(dc_size),
    .dc_ready(dc_ready), .ld_valid(ld_valid), .ld_sq_tail(ld_sq_tail), .ld_addr(ld_addr),
    .ld_size(ld_size), .ld_hit(ld_hit), .ld_stall(ld_stall), .ld_data(ld_data)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int seqOf(input int idx);
    for (int s = m_head; s < m_tail; s++)
      if (s % DEPTH == idx) return s;
    return -1;
  endfunction

  function automatic void modelLoad(input int snap, input logic [31:0] la, input logic [1:0] lsz,
                                    output logic hit, output logic stall, output logic [31:0] d);
    int nb, sb, ov;
    longint a, sa;
    hit = 1'b0; stall = 1'b0; d = '0;
    nb = 1 << lsz;
    for (int s = snap - 1; s >= m_head; s--) begin
      if (!m_ok[s]) begin
        stall = 1'b1;
        return;
      end
      sa = longint'(m_addr[s]);
      sb = 1 << m_size[s];
      ov = 0;
      for (int b = 0; b < nb; b++) begin
        a = longint'(la) + b;
        if (a >= sa && a < sa + sb) ov++;
      end
      if (ov == nb) begin
        hit = 1'b1;
        for (int b = 0; b < nb; b++)
          d[8*b +: 8] = m_data[s][8*(int'(longint'(la) + b - sa)) +: 8];
        return;
      end else if (ov > 0) begin
        stall = 1'b1;
        return;
      end
    end
  endfunction

  task automatic checkAll();
    logic eh, es;
    logic [31:0] ed;
    checkOutput("sq_tail", sq_tail, 32'(m_tail % (2 * DEPTH)));
    checkOutput("free_cnt", free_cnt, 32'(DEPTH - (m_tail - m_head)));
    checkOutput("empty", empty, 32'(m_tail == m_head));
    checkOutput("full", full, 32'(m_tail - m_head == DEPTH));
    checkOutput("dis_idx", dis_idx, 32'(((m_tail + 1) % DEPTH) * 8 + m_tail % DEPTH));
    checkOutput("dc_valid", dc_valid, 32'(m_head != m_commit));
    if (m_head != m_commit) begin
      checkOutput("dc_addr", dc_addr, m_addr[m_head]);
      checkOutput("dc_data", dc_data, m_data[m_head]);
      checkOutput("dc_size", dc_size, 32'(m_size[m_head]));
    end
    for (int l = 0; l < 2; l++) begin
      if (ld_valid[l]) modelLoad(ld_snap[l], ld_addr[l*32 +: 32], ld_size[l*2 +: 2], eh, es, ed);
      else begin
        eh = 1'b0; es = 1'b0; ed = '0;
      end
      checkOutput($sformatf("ld%0d_hit", l), ld_hit[l], 32'(eh));
      checkOutput($sformatf("ld%0d_stall", l), ld_stall[l], 32'(es));
      checkOutput($sformatf("ld%0d_data", l), ld_data[l*32 +: 32], ed);
    end
  endtask

  task automatic modelClock();
    int cn, s;
    logic drn;
    if (reset) begin
      m_head = 0; m_commit = 0; m_tail = 0;
      return;
    end
    drn = (m_head != m_commit) && dc_ready;
    cn  = m_commit + int'(ret_cnt);
    if (flush) m_tail = cn;
    else begin
      for (int p = 0; p < 2; p++) begin
        if (ex_valid[p]) begin
          s = seqOf(int'(ex_idx[p*3 +: 3]));
          if (s >= 0) begin
            m_ok[s]   = 1'b1;
            m_addr[s] = ex_addr[p*32 +: 32];
            m_data[s] = ex_data[p*32 +: 32];
            m_size[s] = ex_size[p*2 +: 2];
          end
        end
      end
      if (int'(dis_cnt) <= DEPTH - (m_tail - m_head)) begin
        for (int k = 0; k < int'(dis_cnt); k++) m_ok[m_tail + k] = 1'b0;
        m_tail += int'(dis_cnt);
      end
    end
    m_commit = cn;
    if (drn) m_head++;
  endtask

  task automatic applyStimulus();
    #2;
    checkAll();
    @(posedge clock);
    modelClock();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; dis_cnt = '0; ret_cnt = '0; flush = 1'b0; dc_ready = 1'b0;
    ex_valid = '0; ex_idx = '0; ex_addr = '0; ex_data = '0; ex_size = '0;
    ld_valid = '0; ld_sq_tail = '0; ld_addr = '0; ld_size = '0;
    ld_snap[0] = 0; ld_snap[1] = 0;
  endtask

  task automatic doReset();
    idle();
    reset = 1'b1;
    @(posedge clock);
    modelClock();
    #1;
    reset = 1'b0;
  endtask

  task automatic setEx(input int p, input int idx, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz);
    ex_valid[p]       = 1'b1;
    ex_idx[p*3 +: 3]  = 3'(idx);
    ex_addr[p*32 +: 32] = a;
    ex_data[p*32 +: 32] = d;
    ex_size[p*2 +: 2] = sz;
  endtask

  task automatic setLoad(input int l, input int snap, input logic [31:0] a, input logic [1:0] sz);
    ld_valid[l]          = 1'b1;
    ld_snap[l]           = snap;
    ld_sq_tail[l*4 +: 4] = 4'(snap % (2 * DEPTH));
    ld_addr[l*32 +: 32]  = a;
    ld_size[l*2 +: 2]    = sz;
  endtask

  function automatic logic [31:0] randAddr(input logic [1:0] sz);
    logic [31:0] a;
    a = 32'h100 + 32'($urandom_range(0, 15));
    if (sz == 2'd1) a[0] = 1'b0;
    if (sz == 2'd2) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic randomCycle();
    int idx, s, avail;
    logic [1:0] sz;
    idle();
    dis_cnt  = 2'($urandom_range(0, 2));
    flush    = ($urandom_range(0, 15) == 0);
    dc_ready = 1'($urandom_range(0, 1));
    for (int p = 0; p < 2; p++) begin
      if ($urandom_range(0, 3) != 0) begin
        if (p == 1 && ex_valid[0] && $urandom_range(0, 3) == 0) idx = int'(ex_idx[2:0]);
        else if (m_tail > m_commit && $urandom_range(0, 3) != 0)
          idx = int'($urandom_range(m_commit, m_tail - 1)) % DEPTH;
        else idx = int'($urandom_range(0, DEPTH - 1));
        s = seqOf(idx);
        if (s < 0 || s >= m_commit) begin
          sz = 2'($urandom_range(0, 2));
          setEx(p, idx, randAddr(sz), $urandom, sz);
        end
      end
    end
    avail = 0;
    while (avail < 2 && m_commit + avail < m_tail && m_ok[m_commit + avail]) avail++;
    ret_cnt = 2'($urandom_range(0, avail));
    for (int l = 0; l < 2; l++) begin
      if ($urandom_range(0, 3) != 0) begin
        sz = 2'($urandom_range(0, 2));
        setLoad(l, int'($urandom_range(m_head, m_tail)), randAddr(sz), sz);
      end
    end
    applyStimulus();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset values and fill-to-full allocation.
    doReset();
    ld_valid = 2'b11;
    #1;
    checkOutput("rst_free_cnt", free_cnt, 32'd8);
    checkOutput("rst_empty", empty, 32'd1);
    checkOutput("rst_full", full, 32'd0);
    checkOutput("rst_dc_valid", dc_valid, 32'd0);
    checkOutput("rst_sq_tail", sq_tail, 32'd0);
    checkOutput("rst_ld_hit", ld_hit, 32'd0);
    checkOutput("rst_ld_stall", ld_stall, 32'd0);
    for (int k = 0; k < 4; k++) begin
      idle();
      dis_cnt = 2'd2;
      #1;
      checkOutput("t1_dis_idx", dis_idx, 32'(((2 * k + 1) << 3) | (2 * k)));
      applyStimulus();
    end
    idle();
    #1;
    checkOutput("t1_full", full, 32'd1);
    checkOutput("t1_free_cnt", free_cnt, 32'd0);
    dis_cnt = 2'd1;
    applyStimulus();
    idle();
    #1;
    checkOutput("t1_reject_tail", sq_tail, 32'h8);
    checkOutput("t1_reject_full", full, 32'd1);

    // Word store forwards a byte; a partial byte store forces a word load to stall.
    doReset();
    dis_cnt = 2'd1;
    applyStimulus();
    idle();
    setEx(0, 0, 32'h1000, 32'hAABBCCDD, 2'd2);
    applyStimulus();
    idle();
    setLoad(0, 1, 32'h1002, 2'd0);
    #1;
    checkOutput("t2_hit", ld_hit[0], 32'd1);
    checkOutput("t2_data", ld_data[31:0], 32'h0000_00BB);
    applyStimulus();
    idle();
    dis_cnt = 2'd1;
    applyStimulus();
    idle();
    setEx(0, 1, 32'h1001, 32'h55, 2'd0);
    applyStimulus();
    idle();
    setLoad(0, 2, 32'h1000, 2'd2);
    #1;
    checkOutput("t2_partial_stall", ld_stall[0], 32'd1);
    checkOutput("t2_partial_hit", ld_hit[0], 32'd0);
    applyStimulus();

    // Two same-address stores: snapshot picks the right one; unknown younger address stalls.
    doReset();
    dis_cnt = 2'd2;
    applyStimulus();
    idle();
    setEx(0, 0, 32'h2000, 32'h11, 2'd0);
    setEx(1, 1, 32'h2000, 32'h22, 2'd0);
    applyStimulus();
    idle();
    setLoad(0, 2, 32'h2000, 2'd0);
    setLoad(1, 1, 32'h2000, 2'd0);
    #1;
    checkOutput("t3_young_data", ld_data[31:0], 32'h22);
    checkOutput("t3_old_data", ld_data[63:32], 32'h11);
    checkOutput("t3_hits", ld_hit, 32'b11);
    applyStimulus();
    idle();
    dis_cnt = 2'd1;
    applyStimulus();
    idle();
    setLoad(0, 3, 32'h2000, 2'd0);
    #1;
    checkOutput("t3_unknown_stall", ld_stall[0], 32'd1);
    applyStimulus();

    // Retire two with a flush of the third, then hold the D-cache off before draining.
    idle();
    ret_cnt = 2'd2;
    flush   = 1'b1;
    applyStimulus();
    for (int c = 0; c < 3; c++) begin
      idle();
      #1;
      checkOutput("t4_hold_valid", dc_valid, 32'd1);
      checkOutput("t4_hold_addr", dc_addr, 32'h2000);
      checkOutput("t4_hold_data", dc_data, 32'h11);
      applyStimulus();
    end
    idle();
    dc_ready = 1'b1;
    applyStimulus();
    idle();
    dc_ready = 1'b1;
    #1;
    checkOutput("t4_second_valid", dc_valid, 32'd1);
    checkOutput("t4_second_data", dc_data, 32'h22);
    applyStimulus();
    idle();
    #1;
    checkOutput("t4_empty", empty, 32'd1);
    checkOutput("t4_done_valid", dc_valid, 32'd0);

    // Flush alongside retire and dispatch: only the retired entry survives and drains.
    doReset();
    dis_cnt = 2'd2;
    applyStimulus();
    idle();
    dis_cnt = 2'd2;
    applyStimulus();
    idle();
    setEx(0, 0, 32'h3000, 32'h77, 2'd2);
    setEx(1, 1, 32'h3004, 32'h88, 2'd2);
    applyStimulus();
    idle();
    ret_cnt = 2'd1;
    flush   = 1'b1;
    dis_cnt = 2'd2;
    applyStimulus();
    idle();
    #1;
    checkOutput("t5_tail", sq_tail, 32'd1);
    checkOutput("t5_free_cnt", free_cnt, 32'd7);
    checkOutput("t5_dc_valid", dc_valid, 32'd1);
    checkOutput("t5_dc_addr", dc_addr, 32'h3000);
    dc_ready = 1'b1;
    applyStimulus();
    idle();
    #1;
    checkOutput("t5_empty", empty, 32'd1);

    // Randomized traffic; pointers wrap many times over this run.
    doReset();
    for (int c = 0; c < 800; c++) randomCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
